pow2_ceil_seq: RTL and testbench
================================

Name: pow2_ceil_seq

Overview:
- Iterative, handshaked pre-stage that directly feeds the combinational log2 decoder.
- The log2 decoder only gives a meaningful degree for an exact power of two. This block takes an arbitrary unsigned number and rounds it up to the next power of two with a bit-serial scan, so its output can go straight into the decoder.
- Also flags whether the input was already exact, and whether rounding up overflowed the width.

Parameters:
- WIDTH, 8, width of the input number and of the power-of-two result (>= 2).
- IDX_W, $clog2(WIDTH), width of the internal scan index and of the MSB-position register.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents in_num.
- in_ready  output  1  block can accept a new number.
- in_num  input  WIDTH  unsigned number to round.
- out_valid  output  1  result available.
- out_ready  input  1  downstream (log2 decoder stage) accepts the result.
- out_pow2  output  WIDTH  one-hot power of two >= in_num; all zeros on overflow.
- out_exact  output  1  in_num was already a nonzero power of two.
- out_ovf  output  1  ceiling is 2^WIDTH, which is not representable.

Behaviour:
- Clock/reset (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE; out_valid=0; out_pow2=0; out_exact=0; out_ovf=0. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst, combinational from state.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Handshake on (in_valid && in_ready) at a rising edge.
  - At that edge: in_num is copied into shift register sh; idx=0; msb=0; ones=0 (2-bit saturating count); go to SCAN.
  - in_num is sampled only at this edge.
- SCAN, one bit per cycle:
  - If sh[0]: msb<=idx, and ones saturates up.
  - Then sh<=sh>>1 and idx<=idx+1.
  - Last scan cycle is idx==WIDTH-1. At that edge: compute the result into the output registers, set out_valid=1, go to DONE.
  - Latency: out_valid rises exactly WIDTH edges after the accepting edge.
- Result rules, using final ones/msb including the last bit:
  - ones==0 (in_num=0): out_pow2=1, exact=0, ovf=0.
  - ones==1: out_pow2=1<<msb, exact=1, ovf=0.
  - ones>=2 and msb<WIDTH-1: out_pow2=1<<(msb+1), exact=0, ovf=0.
  - ones>=2 and msb==WIDTH-1: out_pow2=0, exact=0, ovf=1.
- DONE:
  - Outputs held stable while out_ready=0.
  - On (out_valid && out_ready): out_valid<=0 and go to IDLE. Outputs keep their last value but are don't-care.
  - A new accept is possible on the next cycle.
  - Throughput is one result per WIDTH+2 cycles minimum; no overlap of input and output.
- Async rst at any time, including mid-SCAN or in DONE: the in-flight operation is dropped with no output. All reset values apply immediately.
- The index never wraps, because SCAN exits at WIDTH-1.

Optional Feature:
- Macro: POW2_CEIL_EARLY_EXIT_EN.
- Defined:
  - SCAN also ends at the cycle where (sh>>1)==0 after the current bit, i.e. no higher set bits remain.
  - Result is computed and out_valid is raised at that edge.
  - Latency = max(1, msb_in+1) edges, where msb_in is the highest set bit of in_num. in_num=0 takes 1 edge.
  - Results are identical to the non-EN build.
- Undefined: fixed WIDTH-edge latency for every input.

Test Plan (WIDTH=8, macro undefined unless noted):
- Exact input: accept 0x10 -> out_pow2=0x10, exact=1, ovf=0; out_valid rises exactly 8 edges after the accept edge.
- Non-exact input: 0x13 -> 0x20, exact=0. Input 0x00 -> 0x01, exact=0, ovf=0.
- Overflow: 0x81 -> out_pow2=0x00, ovf=1, exact=0. Input 0x80 -> 0x80, exact=1, ovf=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_pow2/flags stable and in_ready=0. Then out_ready=1 -> in_ready=1 the next cycle, and a new 0x05 is accepted -> 0x08.
- Reset mid-scan: pulse rst 3 cycles after accepting 0x7F -> out_valid stays 0, no result appears, in_ready=1 after release. Next input 0x7F -> 0x80.
- With POW2_CEIL_EARLY_EXIT_EN: 0x03 -> 0x04 after 2 edges; 0x00 -> 0x01 after 1 edge; 0xC0 -> ovf=1 after 8 edges.

Source files
------------

// File: rtl/pow2_ceil_seq.sv
// Bit-serial round-up of an unsigned number to the next power of two.
// Define POW2_CEIL_EARLY_EXIT_EN to stop scanning once no set bits remain.
module pow2_ceil_seq #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_num,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_pow2,
   output logic             out_exact,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] sh;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] msb;
   logic [1:0]       ones;

   logic             cur;
   logic [1:0]       ones_n;
   logic [IDX_W-1:0] msb_n;
   logic             last;
   logic [WIDTH-1:0] hot;

   // Per-bit scan step, including the bit being consumed this cycle
   always_comb begin
      cur    = sh[0];
      ones_n = ones;
      if (cur && ones != 2'd3)
         ones_n = ones + 2'd1;
      msb_n  = cur ? idx : msb;
      hot    = {{(WIDTH-1){1'b0}}, 1'b1} << msb_n;
`ifdef POW2_CEIL_EARLY_EXIT_EN
      last   = ~|sh[WIDTH-1:1];
`else
      last   = (idx == IDX_W'(WIDTH-1));
`endif
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (in_valid)  state_n = SCAN;
         SCAN: if (last)      state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default:             state_n = IDLE;
      endcase
   end

   // Handshake outputs derived from state
   always_comb begin
      in_ready = (state == IDLE) && !rst;
   end

   // Scan datapath and registered result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh        <= '0;
         idx       <= '0;
         msb       <= '0;
         ones      <= '0;
         out_valid <= 1'b0;
         out_pow2  <= '0;
         out_exact <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sh   <= in_num;
                  idx  <= '0;
                  msb  <= '0;
                  ones <= '0;
               end
            end
            SCAN: begin
               sh   <= sh >> 1;
               idx  <= idx + 1'b1;
               msb  <= msb_n;
               ones <= ones_n;
               if (last) begin
                  out_valid <= 1'b1;
                  if (ones_n == 2'd0) begin
                     out_pow2  <= {{(WIDTH-1){1'b0}}, 1'b1};
                     out_exact <= 1'b0;
                     out_ovf   <= 1'b0;
                  end else if (ones_n == 2'd1) begin
                     out_pow2  <= hot;
                     out_exact <= 1'b1;
                     out_ovf   <= 1'b0;
                  end else if (msb_n != IDX_W'(WIDTH-1)) begin
                     out_pow2  <= hot << 1;
                     out_exact <= 1'b0;
                     out_ovf   <= 1'b0;
                  end else begin
                     out_pow2  <= '0;
                     out_exact <= 1'b0;
                     out_ovf   <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pow2_ceil_seq.sv
// Randomized and directed bench for pow2_ceil_seq (WIDTH=8).
// Expected results come from a plain arithmetic ceiling model.
module tb_pow2_ceil_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_num = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_pow2;
   logic         out_exact;
   logic         out_ovf;

   int checks = 0;
   int errors = 0;

   pow2_ceil_seq #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_num(in_num),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pow2(out_pow2),
      .out_exact(out_exact),
      .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: smallest power of two >= n, as plain integers
   function automatic int ref_ceil(input int n);
      int p;
      p = 1;
      while (p < n) p = p * 2;
      return p;
   endfunction

   function automatic int ref_lat(input int n);
`ifdef POW2_CEIL_EARLY_EXIT_EN
      int h;
      h = $clog2(n + 1);
      return (h < 1) ? 1 : h;
`else
      return W;
`endif
   endfunction

   task automatic do_op(input int n, input int bp);
      int lat;
      int p;
      int e_pow;
      int e_ex;
      int e_ov;
      logic [W-1:0] hold;
      p     = ref_ceil(n);
      e_ov  = (p >= (1 << W)) ? 1 : 0;
      e_pow = e_ov ? 0 : p;
      e_ex  = (n != 0 && p == n) ? 1 : 0;
      lat = 0;
      while (!in_ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("in_ready_wait", int'(in_ready), 1);
      in_valid = 1'b1;
      in_num   = W'(n);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_num   = $urandom_range(0, 255);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (out_valid) break;
      end
      chk($sformatf("lat_%02h", n), lat, ref_lat(n));
      chk($sformatf("pow_%02h", n), int'(out_pow2), e_pow);
      chk($sformatf("exact_%02h", n), int'(out_exact), e_ex);
      chk($sformatf("ovf_%02h", n), int'(out_ovf), e_ov);
      chk("busy_in_ready", int'(in_ready), 0);
      hold = out_pow2;
      for (int i = 0; i < bp; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_pow", int'(out_pow2), int'(hold));
         chk("bp_flags", int'({out_exact, out_ovf}), (e_ex << 1) | e_ov);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("drain_valid", int'(out_valid), 0);
      chk("drain_in_ready", int'(in_ready), 1);
   endtask

   initial begin
      int bad;
      #2;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_pow", int'(out_pow2), 0);
      chk("rst_flags", int'({out_exact, out_ovf}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rel_in_ready", int'(in_ready), 1);

      do_op(8'h10, 5);
      do_op(8'h05, 0);
      do_op(8'h13, 1);
      do_op(8'h00, 0);
      do_op(8'h81, 2);
      do_op(8'h80, 0);
      do_op(8'h03, 0);
      do_op(8'hC0, 0);
      do_op(8'hFF, 0);
      do_op(8'h01, 0);

      // Reset while scanning drops the operation
      in_valid = 1'b1;
      in_num   = 8'h7F;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", int'(in_ready), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) bad++;
      end
      chk("no_stale_result", bad, 0);
      chk("post_rst_in_ready", int'(in_ready), 1);
      do_op(8'h7F, 0);

      for (int k = 0; k < 40; k++)
         do_op($urandom_range(0, 255), $urandom_range(0, 3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
